// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit operations on a 4-bit ALU one nibble per clock, LSB first,
// chaining carry between nibbles and returning the result over valid/ready.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// RUN   | driving one nibble per cycle into the ALU, capturing R/P
// DONE  | response held on rsp_* until rsp_ready
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_pin,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_pin,
  input  logic [3:0]       alu_r,
  input  logic [3:0]       alu_p,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  result_reg;
  logic [WIDTH-1:0]  next_result;
  logic [3:0]        s_reg;
  logic              m_reg;
  logic              pin_reg;
  logic              carry_reg;
  logic              run;
  logic              unused_p;

  // Only the nibble carry-out is consumed from the ALU carry vector.
  assign unused_p = ^alu_p[2:0];

  assign run       = (state == RUN);
  assign req_ready = (state == IDLE) && !rst;

  assign alu_a   = run ? a_reg[4*idx +: 4] : 4'h0;
  assign alu_b   = run ? b_reg[4*idx +: 4] : 4'h0;
  assign alu_s   = run ? s_reg : 4'h0;
  assign alu_m   = run ? m_reg : 1'b0;
  assign alu_pin = run ? carry_reg : 1'b0;

  // Result as it will stand after this edge, so the zero flag sees the top nibble.
  always_comb begin
    next_result = result_reg;
    next_result[4*idx +: 4] = alu_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= 4'h0;
      m_reg      <= 1'b0;
      pin_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_reg      <= req_a;
            b_reg      <= req_b;
            s_reg      <= req_s;
            m_reg      <= req_m;
            pin_reg    <= req_pin;
            carry_reg  <= req_pin;
            idx        <= '0;
            result_reg <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          result_reg <= next_result;
          // Logic mode has no chaining: the original carry-in is re-applied.
          carry_reg  <= m_reg ? pin_reg : alu_p[3];
          if (idx == LAST) begin
            idx        <= '0;
            rsp_result <= next_result;
            rsp_carry  <= alu_p[3];
            rsp_zero   <= (next_result == '0);
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Control-unit block that runs WIDTH-bit operations on the existing 4-bit parallel ALU, one nibble per clock, LSB nibble first.
- Accepts an operation request (operands, S, M, Pin) over a valid/ready handshake and drives the ALU A/B/S/M/Pin inputs.
- Captures the ALU R/P outputs and chains the carry between nibbles.
- Returns the assembled result, final carry and zero flag over a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and at least 4. NIB = WIDTH/4 is derived locally.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_s  in  4  ALU function select
- req_m  in  1  ALU mode (0 = arithmetic, 1 = logic)
- req_pin  in  1  initial carry-in
- alu_a  out  4  nibble of A to the ALU
- alu_b  out  4  nibble of B to the ALU
- alu_s  out  4  function select to the ALU
- alu_m  out  1  mode to the ALU
- alu_pin  out  1  carry-in to the ALU
- alu_r  in  4  ALU result
- alu_p  in  4  ALU carry vector; alu_p[3] is the nibble carry-out
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  WIDTH  assembled result
- rsp_carry  out  1  final carry
- rsp_zero  out  1  high when rsp_result == 0

Behaviour:
- Clock and reset: single clock domain; rst is synchronous and active-high.
- States:
  - IDLE, RUN, DONE.
  - Reset puts the block in IDLE with idx=0, carry_reg=0, and all operand/result registers cleared.
  - Reset values: rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0.
  - While rst is high, req_ready=0. After reset it is 1, because req_ready = (state==IDLE) and !rst.
- IDLE:
  - On req_valid && req_ready: latch req_a, req_b, req_s, req_m; set carry_reg=req_pin and idx=0; go to RUN.
  - req_* inputs are ignored outside the accept cycle.
- RUN:
  - ALU outputs are combinational from registers:
    - alu_a = a_reg[4*idx +: 4], alu_b = b_reg[4*idx +: 4]
    - alu_s = s_reg, alu_m = m_reg, alu_pin = carry_reg
  - At each clock edge:
    - result_reg[4*idx +: 4] <= alu_r
    - carry_reg <= m_reg ? pin_reg : alu_p[3]. In logic mode there is no chaining; the original req_pin is re-applied every nibble.
    - idx <= idx+1
  - When idx == NIB-1, the same edge also loads rsp_result, sets rsp_carry = alu_p[3] and rsp_zero = (assembled result == 0), and moves to DONE.
- DONE:
  - rsp_valid=1; rsp_* are held stable until rsp_ready.
  - On rsp_ready: rsp_valid <= 0, go to IDLE.
  - req_ready=0 throughout DONE.
- ALU drive outside RUN: alu_a=0, alu_b=0, alu_s=0, alu_m=0, alu_pin=0.
- Latency and throughput:
  - A request accepted at edge k has RUN cycles k+1 .. k+NIB; rsp_valid is high after edge k+NIB.
  - Minimum spacing is one operation per NIB+2 cycles, with rsp_ready tied high.
- Boundary conditions:
  - WIDTH=4 (NIB=1): RUN lasts exactly one cycle.
  - A carry out of the top nibble appears only in rsp_carry; it never wraps into bit 0.
  - rsp_ready asserted outside DONE has no effect.
  - req_valid asserted outside IDLE is not accepted. The requester holds it until req_ready.
  - Reset in RUN or DONE aborts the operation: no response, and outputs return to reset values on that edge.

Test Plan:
Bench ALU model: M=0 gives R = A+B+Pin and P[3] = carry-out; M=1 gives R = A^B and P=0. WIDTH=16 unless stated.
1. Reset, then req a=16'h00FF, b=16'h0001, m=0, pin=0 -> RUN shows alu_a nibbles F,F,0,0 and alu_pin 0,1,1,0. rsp_result=16'h0100, rsp_carry=0, rsp_zero=0; rsp_valid rises 4 cycles after accept.
2. a=16'hFFFF, b=16'h0001, m=0, pin=0 -> rsp_result=16'h0000, rsp_carry=1, rsp_zero=1.
3. a=16'hA5A5, b=16'h0F0F, m=1, s=4'b0110, pin=1 -> rsp_result=16'hAAAA, alu_pin=1 on every nibble, alu_s=4'b0110 throughout.
4. Hold rsp_ready=0 for 5 cycles in DONE while pulsing req_valid -> rsp_* stable, req_ready=0, no second accept. Raising rsp_ready returns to IDLE with req_ready=1 the next cycle.
5. Assert rst at RUN idx=2 -> next cycle state IDLE, rsp_valid=0, alu_* all 0. A new request then completes correctly (e.g. 16'h1234+16'h1111 = 16'h2345).
6. WIDTH=4: a=4'hF, b=4'h1, pin=0, m=0 -> one RUN cycle, rsp_result=4'h0, rsp_carry=1, rsp_zero=1.
